uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver that sits downstream of the UART transmit stage on the same
//   link. It recovers 8-bit frames from the idle-high line: start bit low, 8 data
//   bits MSB first, stop bit high. Each good byte is presented as a one-cycle
//   valid pulse. Bad stop bits and start-bit glitches are also reported.
// PARAMETERS
//   CLKS_PER_BIT  10416  clk cycles per bit period (100 MHz / 9600 baud); must be >= 4
// PORTS
//   clk        in   1  system clock; all logic is on the rising edge
//   nreset     in   1  asynchronous, active-low reset
//   rx         in   1  serial line, asynchronous to clk, idle high
//   data       out  8  last good received byte
//   valid      out  1  one-cycle pulse; data is new this cycle
//   frame_err  out  1  one-cycle pulse; stop bit was sampled low
//   busy       out  1  high whenever the FSM is not in IDLE
// BEHAVIOUR
//   - Reset (nreset=0, takes effect immediately):
//     - data=0, valid=0, frame_err=0, busy=0.
//     - Both synchroniser flops=1, FSM=IDLE, counters=0, shift register=0.
//   - Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
//   - Counters:
//     - tick: $clog2(CLKS_PER_BIT) bits, zeroed on every state change.
//     - bit_idx: 3 bits.
//     - H = CLKS_PER_BIT/2, using integer truncation.
//   - FSM states: IDLE, START, DATA, STOP, BREAK.
//     - IDLE: when rx_s==0, go to START with tick=0.
//     - START: when tick==H-1, sample rx_s.
//       - rx_s==0: go to DATA with tick=0, bit_idx=0.
//       - rx_s==1: glitch; go to IDLE with no output pulse.
//     - DATA: when tick==CLKS_PER_BIT-1, set shift[7-bit_idx]=rx_s and tick=0.
//       - bit_idx==7: go to STOP.
//       - otherwise: bit_idx++.
//     - STOP: when tick==CLKS_PER_BIT-1, sample rx_s.
//       - rx_s==1: data<=shift, valid=1 for exactly one cycle, go to IDLE.
//       - rx_s==0: frame_err=1 for one cycle, data unchanged, go to BREAK.
//     - BREAK: stay until rx_s==1, then go to IDLE. A new start bit is only
//       recognised after the line has returned high.
//   - Latency: valid rises exactly H + 9*CLKS_PER_BIT clk edges after the edge
//     that enters START.
//   - Sampling point: every bit is sampled at its mid-point.
//   - Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge
//     right after the stop bit is accepted. No gap beyond one stop bit is needed.
//   - Output rules:
//     - valid and frame_err are never high in the same cycle.
//     - No backpressure: the consumer must capture data on valid.
//     - data holds its value until the next valid.
//   - Reset mid-frame: the partial frame is discarded and no pulse follows.
//     After release the block waits in IDLE for a fresh falling edge.
// TESTING  (CLKS_PER_BIT=16 unless stated)
//   1 Hold nreset=0 with rx toggling -> data=0, valid=0, frame_err=0, busy=0
//     throughout.
//   2 Send 0xA5 MSB first with stop=1 -> exactly one valid pulse, data=0xA5,
//     frame_err=0, busy=0 afterwards. Pulse timing matches the latency rule
//     within 2 clocks of the rx falling edge.
//   3 Pull rx low for 4 clocks, then high -> busy pulses, then IDLE. No valid,
//     no frame_err.
//   4 After test 2, send 0x3C with stop=0 and hold rx low for 3 more bit times
//     -> one frame_err pulse, no valid, data stays 0xA5, busy stays high until
//     rx rises.
//   5 Send 0x00 and 0xFF back-to-back, one stop bit each -> two valid pulses
//     carrying 0x00 then 0xFF, no frame_err.
//   6 Assert nreset during data bit 4 of 0x81, then release and send 0x5A
//     -> no pulse for 0x81, then one valid pulse with data=0x5A.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit MSB-first UART receiver with mid-bit sampling
// Reports good bytes on valid and a low stop bit on frame_err.
module uart_rx #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rx_s;
   logic [TW-1:0] tick, tick_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [7:0]    data_nxt;
   logic          valid_nxt, frame_err_nxt;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!rx_s) state_nxt = START;
         START:   if (tick == HALF_LAST) state_nxt = rx_s ? IDLE : DATA;
         DATA:    if (tick == BIT_LAST && bit_idx == 3'd7) state_nxt = STOP;
         STOP:    if (tick == BIT_LAST) state_nxt = rx_s ? IDLE : BREAK;
         BREAK:   if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // STOP returns to IDLE at mid-stop-bit so a back-to-back start edge is caught.
   always_comb begin
      tick_nxt      = tick + TW'(1);
      bit_idx_nxt   = bit_idx;
      shift_nxt     = shift;
      data_nxt      = data;
      valid_nxt     = 1'b0;
      frame_err_nxt = 1'b0;
      busy          = (state != IDLE);
      if (state_nxt != state || state == IDLE || state == BREAK ||
          (state == DATA && tick == BIT_LAST))
         tick_nxt = '0;
      case (state)
         START: if (state_nxt == DATA) bit_idx_nxt = 3'd0;
         DATA: begin
            if (tick == BIT_LAST) begin
               shift_nxt[3'd7 - bit_idx] = rx_s;
               bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (tick == BIT_LAST) begin
               if (rx_s) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
               end else begin
                  frame_err_nxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tick      <= '0;
         bit_idx   <= 3'd0;
         shift     <= 8'h00;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         tick      <= tick_nxt;
         bit_idx   <= bit_idx_nxt;
         shift     <= shift_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= frame_err_nxt;
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - random and directed bench for uart_rx against a sampling-point model
// The whole rx/reset waveform is built first, the model predicts every cycle, then it is replayed.
module tb_uart_rx;
   localparam int CPB  = 16;
   localparam int H    = CPB / 2;
   localparam int MAXC = 30000;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .nreset(nreset), .rx(rx),
      .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       v;
      logic       fe;
      logic       b;
      logic [7:0] d;
   } chk_t;

   bit         rxq[$];
   bit         rsq[$];
   chk_t       chks[$];
   bit         ev[MAXC];
   bit         ef[MAXC];
   bit         eb[MAXC];
   logic [7:0] ed[MAXC];
   int         nvec = 0;
   int         nerr = 0;

   task automatic push(input bit v, input bit r, input int n);
      for (int i = 0; i < n; i++) begin
         rxq.push_back(v);
         rsq.push_back(r);
      end
   endtask

   task automatic push_frame(input logic [7:0] b, input bit stop, output int f);
      f = rxq.size();
      push(1'b0, 1'b0, CPB);
      for (int k = 7; k >= 0; k--) push(b[k], 1'b0, CPB);
      push(stop, 1'b0, CPB);
   endtask

   task automatic add_chk(input int cyc, input logic v, input logic fe, input logic b,
                          input logic [7:0] d);
      chk_t t;
      t.cyc = cyc; t.v = v; t.fe = fe; t.b = b; t.d = d;
      chks.push_back(t);
   endtask

   // Line value the receiver logic sees in cycle c: two flops behind rx, forced high by reset.
   function automatic bit ls(input int c);
      if (c < 2 || c >= rxq.size()) return 1'b1;
      if (rsq[c] || rsq[c-1] || rsq[c-2]) return 1'b1;
      return rxq[c-2];
   endfunction

   task automatic build_model();
      int n, c, s0, ret, pc, rr, b, end_c;
      logic [7:0] cur, byt;
      bit pulse_ok;
      n = rxq.size();
      for (int i = 0; i < n; i++) begin
         ev[i] = 1'b0; ef[i] = 1'b0; eb[i] = 1'b0; ed[i] = 8'h00;
      end
      c = 0;
      cur = 8'h00;
      while (c < n) begin
         if (rsq[c]) begin
            cur = 8'h00;
            c++;
            continue;
         end
         ed[c] = cur;
         if (ls(c)) begin
            c++;
            continue;
         end
         s0 = c + 1;
         pc = -1;
         byt = 8'h00;
         if (ls(s0 + H - 1)) begin
            ret = s0 + H;
         end else begin
            for (int k = 0; k < 8; k++) byt[7-k] = ls(s0 + H + (k + 1) * CPB - 1);
            pc = s0 + H + 9 * CPB;
            if (ls(pc - 1)) begin
               ret = pc;
            end else begin
               b = pc;
               while (b < n && !ls(b)) b++;
               ret = b + 1;
            end
         end
         rr = -1;
         for (int i = s0; i <= ret && i < n; i++) begin
            if (rsq[i]) begin
               rr = i;
               break;
            end
         end
         pulse_ok = (pc >= 0) && !(rr >= 0 && rr <= pc);
         end_c = (rr >= 0) ? rr : ret;
         for (int i = s0; i < end_c && i < n; i++) begin
            eb[i] = 1'b1;
            ed[i] = cur;
         end
         if (pulse_ok && pc < n) begin
            if (ret == pc) begin
               ev[pc] = 1'b1;
               cur = byt;
            end else begin
               ef[pc] = 1'b1;
            end
         end
         c = end_c;
      end
   endtask

   task automatic pin(input string name, input bit ok);
      nvec++;
      if (!ok) begin
         nerr++;
         $display("FAIL %s: model prediction differs from hand-computed value", name);
      end
   endtask

   initial begin
      int fa, fg, f3c, f00, fff, f81, f5a, f, j, sel, nv;
      logic [7:0] rb;

      for (int i = 0; i < 20; i++) push(1'($urandom_range(0, 1)), 1'b1, 1);
      push(1'b1, 1'b0, 10);
      push_frame(8'hA5, 1'b1, fa);
      push(1'b1, 1'b0, 30);
      fg = rxq.size();
      push(1'b0, 1'b0, 4);
      push(1'b1, 1'b0, 40);
      push_frame(8'h3C, 1'b0, f3c);
      push(1'b0, 1'b0, 3 * CPB);
      push(1'b1, 1'b0, 40);
      push_frame(8'h00, 1'b1, f00);
      push_frame(8'hFF, 1'b1, fff);
      push(1'b1, 1'b0, 40);
      push_frame(8'h81, 1'b1, f81);
      for (int i = f81 + 85; i < rxq.size(); i++) rxq[i] = 1'b1;
      for (int i = 0; i < 3; i++) rsq[f81 + 85 + i] = 1'b1;
      push(1'b1, 1'b0, 40);
      push_frame(8'h5A, 1'b1, f5a);
      push(1'b1, 1'b0, 40);

      for (int it = 0; it < 60; it++) begin
         sel = $urandom_range(0, 9);
         rb = 8'($urandom_range(0, 255));
         if (sel <= 5) begin
            push_frame(rb, 1'b1, f);
         end else if (sel == 6) begin
            push_frame(rb, 1'b0, f);
            push(1'b0, 1'b0, $urandom_range(0, 3 * CPB));
         end else if (sel == 7) begin
            push(1'b0, 1'b0, $urandom_range(1, 12));
            push(1'b1, 1'b0, $urandom_range(20, 40));
         end else if (sel == 8) begin
            push_frame(rb, 1'b1, f);
            push(1'b1, 1'b0, 10);
            j = f + $urandom_range(0, 159);
            for (int k = 0; k < $urandom_range(1, 3); k++) rsq[j + k] = 1'b1;
         end else begin
            push_frame(rb, 1'b1, f);
            push_frame(~rb, 1'b1, f);
         end
         push(1'b1, 1'b0, $urandom_range(0, 20));
      end
      push(1'b1, 1'b0, 300);

      if (rxq.size() > MAXC) begin
         $display("FAIL stim_size: got %0d cycles, limit %0d", rxq.size(), MAXC);
         $fatal(1, "stimulus too long");
      end

      add_chk(5, 1'b0, 1'b0, 1'b0, 8'h00);
      add_chk(15, 1'b0, 1'b0, 1'b0, 8'h00);
      add_chk(fa + 154, 1'b0, 1'b0, 1'b1, 8'h00);
      add_chk(fa + 155, 1'b1, 1'b0, 1'b0, 8'hA5);
      add_chk(fg + 5, 1'b0, 1'b0, 1'b1, 8'hA5);
      add_chk(fg + 12, 1'b0, 1'b0, 1'b0, 8'hA5);
      add_chk(f3c + 155, 1'b0, 1'b1, 1'b1, 8'hA5);
      add_chk(f3c + 200, 1'b0, 1'b0, 1'b1, 8'hA5);
      add_chk(f3c + 215, 1'b0, 1'b0, 1'b0, 8'hA5);
      add_chk(f00 + 155, 1'b1, 1'b0, 1'b0, 8'h00);
      add_chk(fff + 155, 1'b1, 1'b0, 1'b0, 8'hFF);
      add_chk(f81 + 86, 1'b0, 1'b0, 1'b0, 8'h00);
      add_chk(f5a + 155, 1'b1, 1'b0, 1'b0, 8'h5A);

      build_model();

      pin("model_a5", ev[fa + 155] && ed[fa + 155] == 8'hA5);
      pin("model_3c_ferr", ef[f3c + 155] && !ev[f3c + 155]);
      pin("model_ff", ev[fff + 155] && ed[fff + 155] == 8'hFF && fff == f00 + 160);
      nv = 0;
      for (int i = f81; i < f5a; i++) nv += int'(ev[i]);
      pin("model_reset_drop", nv == 0);

      for (int c = 0; c < rxq.size(); c++) begin
         @(posedge clk);
         #1;
         rx = rxq[c];
         nreset = !rsq[c];
         @(negedge clk);
         nvec++;
         if (valid !== ev[c] || frame_err !== ef[c] || busy !== eb[c] || data !== ed[c]) begin
            nerr++;
            $display("FAIL cycle %0d: got v=%b fe=%b busy=%b data=%02h, want v=%b fe=%b busy=%b data=%02h",
                     c, valid, frame_err, busy, data, ev[c], ef[c], eb[c], ed[c]);
         end
         foreach (chks[i]) begin
            if (chks[i].cyc == c) begin
               nvec++;
               if (valid !== chks[i].v || frame_err !== chks[i].fe || busy !== chks[i].b ||
                   data !== chks[i].d) begin
                  nerr++;
                  $display("FAIL literal@%0d: got v=%b fe=%b busy=%b data=%02h, want v=%b fe=%b busy=%b data=%02h",
                           c, valid, frame_err, busy, data,
                           chks[i].v, chks[i].fe, chks[i].b, chks[i].d);
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
